bioee_sdram_ring_negotiator: RTL and testbench

- Multi-channel successor to the single-stream SDRAM page negotiator.
- Arbitrates page-write and page-read commands to the existing sdramctrl for NCH independent data streams. Each stream owns a private circular row region in SDRAM.
- Tracks per-channel occupancy with wrap-around, and offers a selectable full-ring policy: stall, or overwrite the oldest row.
- Adds programmable fill triggers, sticky fault flags and a command watchdog. Sits between the per-channel in/out FIFO pairs and sdramctrl, entirely in the SDRAM clock domain.

---
 rtl/bioee_sdram_ring_negotiator.sv | 225 ++++++++++++++++++++++
 tb/tb_bioee_sdram_ring_negotiator.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bioee_sdram_ring_negotiator.sv
// Page-command negotiator between NCH per-channel FIFO pairs and sdramctrl.
// Each channel owns a private circular row region in SDRAM. The block keeps
// per-channel write/read pointers and occupancy, and picks one channel at a
// time in round-robin order. Within the picked channel a write beats a read.
// When a ring is full, new writes either stall or overwrite the oldest row,
// depending on OVF_MODE.
//
// Ports:
//   sdram_clk, resetin_n      clock, asynchronous active-low reset
//   wr_enable, rd_enable      global enables for page writes / page reads
//   flush[NCH]                per-channel ring-empty request (pulse or level)
//   in_level, out_level       packed per-channel FIFO counts (LVL_W each)
//   cmd_pagewrite/pageread    command requests to sdramctrl
//   cmd_ack, cmd_done         sdramctrl handshake
//   rowaddr, cmd_ch           row {pad, channel, ring ptr} and served channel
//   busy                      high when not idle
//   fill_trigger[NCH]         registered (occupancy > TRIG_ROWS)
//   overflow[NCH]             sticky: write refused or oldest row overwritten
//   timeout_fault             sticky: command watchdog expired
module bioee_sdram_ring_negotiator #(
  parameter int CH_W      = 1,
  parameter int ROW_W     = 15,
  parameter int RING_BITS = 12,
  parameter int LVL_W     = 11,
  parameter int WR_THRESH = 512,
  parameter int RD_LIMIT  = 1024,
  parameter int TRIG_ROWS = 32,
  parameter int OVF_MODE  = 0,
  parameter int TIMEOUT   = 4095,
  localparam int NCH      = 1 << CH_W
) (
  input  logic                   sdram_clk,
  input  logic                   resetin_n,
  input  logic                   wr_enable,
  input  logic                   rd_enable,
  input  logic [NCH-1:0]         flush,
  input  logic [NCH*LVL_W-1:0]   in_level,
  input  logic [NCH*LVL_W-1:0]   out_level,
  output logic                   cmd_pagewrite,
  output logic                   cmd_pageread,
  input  logic                   cmd_ack,
  input  logic                   cmd_done,
  output logic [ROW_W-1:0]       rowaddr,
  output logic [CH_W-1:0]        cmd_ch,
  output logic                   busy,
  output logic [NCH-1:0]         fill_trigger,
  output logic [NCH-1:0]         overflow,
  output logic                   timeout_fault
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [RING_BITS:0] OCC_FULL = {1'b1, {RING_BITS{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_WACK, S_RACK, S_BUSY} state_t;

  state_t                 state_q, state_d;
  logic [RING_BITS-1:0]   wptr_q [NCH];
  logic [RING_BITS-1:0]   wptr_d [NCH];
  logic [RING_BITS-1:0]   rptr_q [NCH];
  logic [RING_BITS-1:0]   rptr_d [NCH];
  logic [RING_BITS:0]     occ_q  [NCH];
  logic [RING_BITS:0]     occ_d  [NCH];
  logic [CH_W-1:0]        rr_q, rr_d;
  logic [CH_W-1:0]        cmd_ch_q, cmd_ch_d;
  logic [ROW_W-1:0]       rowaddr_q, rowaddr_d;
  logic [NCH-1:0]         fill_q, fill_d;
  logic [NCH-1:0]         ovf_q, ovf_d;
  logic [NCH-1:0]         pend_q, pend_d;
  logic                   tmo_q, tmo_d;
  logic [WD_W-1:0]        wdog_q, wdog_d;

  logic [NCH-1:0]         wr_want, wreq, rreq, ring_full;
  logic                   found, pick_wr;
  logic [CH_W-1:0]        pick, idx;

  // Per-channel request qualification and fill trigger source.
  always_comb begin
    wr_want   = '0;
    wreq      = '0;
    rreq      = '0;
    ring_full = '0;
    fill_d    = '0;
    for (int c = 0; c < NCH; c++) begin
      ring_full[c] = (occ_q[c] == OCC_FULL);
      wr_want[c]   = wr_enable &&
                     (32'(in_level[c*LVL_W +: LVL_W]) >= 32'(WR_THRESH));
      wreq[c]      = wr_want[c] && (!ring_full[c] || OVF_MODE == 1);
      rreq[c]      = rd_enable && (occ_q[c] != '0) &&
                     (32'(out_level[c*LVL_W +: LVL_W]) <= 32'(RD_LIMIT));
      fill_d[c]    = 32'(occ_q[c]) > 32'(TRIG_ROWS);
    end
  end

  // Round-robin scan starting at rr; NCH is a power of two so the CH_W-bit
  // sum wraps modulo NCH on its own.
  always_comb begin
    found   = 1'b0;
    pick    = rr_q;
    pick_wr = 1'b0;
    idx     = rr_q;
    for (int i = 0; i < NCH; i++) begin
      idx = rr_q + CH_W'(i);
      if (!found && (wreq[idx] || rreq[idx])) begin
        found   = 1'b1;
        pick    = idx;
        pick_wr = wreq[idx];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    occ_d     = occ_q;
    rr_d      = rr_q;
    cmd_ch_d  = cmd_ch_q;
    rowaddr_d = rowaddr_q;
    ovf_d     = ovf_q;
    pend_d    = pend_q | flush;
    tmo_d     = tmo_q;
    wdog_d    = wdog_q;
    case (state_q)
      S_IDLE: begin
        for (int c = 0; c < NCH; c++) begin
          if (OVF_MODE == 0 && wr_want[c] && ring_full[c]) ovf_d[c] = 1'b1;
        end
        if (|pend_q) begin
          // Flush cycle: no command issued. Clear only what was applied; a
          // level flush re-latches and lets arbitration run in between.
          for (int c = 0; c < NCH; c++) begin
            if (pend_q[c]) begin
              rptr_d[c] = wptr_q[c];
              occ_d[c]  = '0;
            end
          end
          pend_d = flush & ~pend_q;
        end else if (found) begin
          cmd_ch_d  = pick;
          rowaddr_d = ROW_W'({pick, (pick_wr ? wptr_q[pick] : rptr_q[pick])});
          state_d   = pick_wr ? S_WACK : S_RACK;
          wdog_d    = '0;
        end
      end
      S_WACK, S_RACK: begin
        if (cmd_ack) begin
          if (state_q == S_WACK) begin
            wptr_d[cmd_ch_q] = wptr_q[cmd_ch_q] + 1'b1;
            if (occ_q[cmd_ch_q] == OCC_FULL) begin
              // Overwrite mode: the oldest row is sacrificed.
              rptr_d[cmd_ch_q] = rptr_q[cmd_ch_q] + 1'b1;
              ovf_d[cmd_ch_q]  = 1'b1;
            end else begin
              occ_d[cmd_ch_q]  = occ_q[cmd_ch_q] + 1'b1;
            end
          end else begin
            rptr_d[cmd_ch_q] = rptr_q[cmd_ch_q] + 1'b1;
            occ_d[cmd_ch_q]  = occ_q[cmd_ch_q] - 1'b1;
          end
          rr_d    = cmd_ch_q + 1'b1;
          state_d = S_BUSY;
          wdog_d  = '0;
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wdog_d  = wdog_q + 1'b1;
        end
      end
      S_BUSY: begin
        if (cmd_done) begin
          state_d = S_IDLE;
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wdog_d  = wdog_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sdram_clk or negedge resetin_n) begin
    if (!resetin_n) begin
      state_q   <= S_IDLE;
      for (int c = 0; c < NCH; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        occ_q[c]  <= '0;
      end
      rr_q      <= '0;
      cmd_ch_q  <= '0;
      rowaddr_q <= '0;
      fill_q    <= '0;
      ovf_q     <= '0;
      pend_q    <= '0;
      tmo_q     <= 1'b0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      occ_q     <= occ_d;
      rr_q      <= rr_d;
      cmd_ch_q  <= cmd_ch_d;
      rowaddr_q <= rowaddr_d;
      fill_q    <= fill_d;
      ovf_q     <= ovf_d;
      pend_q    <= pend_d;
      tmo_q     <= tmo_d;
      wdog_q    <= wdog_d;
    end
  end

  assign cmd_pagewrite = (state_q == S_WACK);
  assign cmd_pageread  = (state_q == S_RACK);
  assign busy          = (state_q != S_IDLE);
  assign rowaddr       = rowaddr_q;
  assign cmd_ch        = cmd_ch_q;
  assign fill_trigger  = fill_q;
  assign overflow      = ovf_q;
  assign timeout_fault = tmo_q;

endmodule

// File: tb/tb_bioee_sdram_ring_negotiator.sv
module tb_bioee_sdram_ring_negotiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, rd_en;
  logic [1:0]  flush;
  logic [21:0] in_lvl, out_lvl;

  logic        cw_a, cr_a, ack_a, done_a, busy_a, tmo_a, ch_a;
  logic [14:0] row_a;
  logic [1:0]  fill_a, ovf_a;
  logic        cw_b, cr_b, ack_b, done_b, busy_b, tmo_b, ch_b;
  logic [14:0] row_b;
  logic [1:0]  fill_b, ovf_b;

  logic        ack_en_a;
  int          done_dly_a;
  int          acnt_a, dcnt_a, acks_a;
  int          acnt_b, dcnt_b, acks_b;
  int          n_run = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  bioee_sdram_ring_negotiator dut_a (
    .sdram_clk(clk), .resetin_n(rst_n), .wr_enable(wr_en), .rd_enable(rd_en),
    .flush(flush), .in_level(in_lvl), .out_level(out_lvl),
    .cmd_pagewrite(cw_a), .cmd_pageread(cr_a), .cmd_ack(ack_a), .cmd_done(done_a),
    .rowaddr(row_a), .cmd_ch(ch_a), .busy(busy_a), .fill_trigger(fill_a),
    .overflow(ovf_a), .timeout_fault(tmo_a));

  bioee_sdram_ring_negotiator #(.RING_BITS(2), .OVF_MODE(1)) dut_b (
    .sdram_clk(clk), .resetin_n(rst_n), .wr_enable(wr_en), .rd_enable(rd_en),
    .flush(flush), .in_level(in_lvl), .out_level(out_lvl),
    .cmd_pagewrite(cw_b), .cmd_pageread(cr_b), .cmd_ack(ack_b), .cmd_done(done_b),
    .rowaddr(row_b), .cmd_ch(ch_b), .busy(busy_b), .fill_trigger(fill_b),
    .overflow(ovf_b), .timeout_fault(tmo_b));

  // sdramctrl stand-ins: ack on the 3rd command cycle, done after a delay.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_a <= 1'b0; done_a <= 1'b0; acnt_a <= 0; dcnt_a <= 0; acks_a <= 0;
    end else begin
      ack_a  <= 1'b0;
      done_a <= 1'b0;
      if (ack_a && (cw_a || cr_a)) acks_a <= acks_a + 1;
      if ((cw_a || cr_a) && !ack_a && ack_en_a) begin
        if (acnt_a == 1) begin ack_a <= 1'b1; acnt_a <= 0; end
        else acnt_a <= acnt_a + 1;
      end else if (!(cw_a || cr_a)) acnt_a <= 0;
      if (busy_a && !cw_a && !cr_a && !done_a) begin
        if (dcnt_a >= done_dly_a) begin done_a <= 1'b1; dcnt_a <= 0; end
        else dcnt_a <= dcnt_a + 1;
      end else dcnt_a <= 0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_b <= 1'b0; done_b <= 1'b0; acnt_b <= 0; dcnt_b <= 0; acks_b <= 0;
    end else begin
      ack_b  <= 1'b0;
      done_b <= 1'b0;
      if (ack_b && (cw_b || cr_b)) acks_b <= acks_b + 1;
      if ((cw_b || cr_b) && !ack_b) begin
        if (acnt_b == 1) begin ack_b <= 1'b1; acnt_b <= 0; end
        else acnt_b <= acnt_b + 1;
      end else if (!(cw_b || cr_b)) acnt_b <= 0;
      if (busy_b && !cw_b && !cr_b && !done_b) begin done_b <= 1'b1; dcnt_b <= 0; end
      else dcnt_b <= 0;
    end
  end

  typedef struct {
    logic        wr;
    logic        rd;
    logic [10:0] in0;
    logic [10:0] in1;
    logic        cmd;
    logic        isw;
    logic        ch;
    logic [14:0] row;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; flush = 2'b00;
    in_lvl = '0; out_lvl = '0; ack_en_a = 1'b1; done_dly_a = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_cmd(input bit sel, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (sel ? (cw_b || cr_b) : (cw_a || cr_a)) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_acks(input bit sel, input int n, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if ((sel ? acks_b : acks_a) >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (!busy_a) begin ok = 1'b1; break; end
    end
  endtask

  initial begin
    bit ok;
    bit saw;
    int n;
    logic        exp_ch  [3];
    logic [14:0] exp_row [3];

    //           wr    rd    in0       in1      cmd   isw   ch    row
    tbl[0] = '{1'b1, 1'b1, 11'd600,  11'd0,    1'b1, 1'b1, 1'b0, 15'h0000};
    tbl[1] = '{1'b1, 1'b0, 11'd511,  11'd512,  1'b1, 1'b1, 1'b1, 15'h1000};
    tbl[2] = '{1'b0, 1'b0, 11'd600,  11'd600,  1'b0, 1'b0, 1'b0, 15'h0000};
    tbl[3] = '{1'b1, 1'b0, 11'd511,  11'd511,  1'b0, 1'b0, 1'b0, 15'h0000};
    tbl[4] = '{1'b1, 1'b0, 11'd2047, 11'd2047, 1'b1, 1'b1, 1'b0, 15'h0000};
    tbl[5] = '{1'b1, 1'b1, 11'd0,    11'd0,    1'b0, 1'b0, 1'b0, 15'h0000};
    exp_ch[0]  = 1'b0; exp_ch[1]  = 1'b1;     exp_ch[2]  = 1'b0;
    exp_row[0] = 15'h0; exp_row[1] = 15'h1000; exp_row[2] = 15'h0001;

    // Reset state
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; flush = 2'b00;
    in_lvl = '0; out_lvl = '0; ack_en_a = 1'b1; done_dly_a = 0;
    @(negedge clk);
    chk("rst_pagewrite", cw_a, 0);
    chk("rst_pageread", cr_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_rowaddr", row_a, 0);
    chk("rst_cmd_ch", ch_a, 0);
    chk("rst_overflow", ovf_a, 0);
    chk("rst_timeout", tmo_a, 0);
    chk("rst_fill", fill_a, 0);

    // Qualification / first-pick table
    for (int v = 0; v < 6; v++) begin
      do_reset();
      wr_en = tbl[v].wr; rd_en = tbl[v].rd;
      in_lvl = {tbl[v].in1, tbl[v].in0};
      wait_cmd(1'b0, 20, ok);
      chk($sformatf("tbl%0d_cmd", v), ok, tbl[v].cmd);
      if (ok) begin
        chk($sformatf("tbl%0d_isw", v), cw_a, tbl[v].isw);
        chk($sformatf("tbl%0d_ch", v), ch_a, tbl[v].ch);
        chk($sformatf("tbl%0d_row", v), row_a, tbl[v].row);
      end
    end

    // Single-channel writes: 3-cycle request, consecutive rows
    do_reset();
    done_dly_a = 20;
    in_lvl = {11'd0, 11'd600}; wr_en = 1'b1;
    wait_cmd(1'b0, 20, ok);
    chk("s1_first_cmd", ok, 1);
    chk("s1_row0", row_a, 15'h0000);
    n = 0;
    while (cw_a && n < 50) begin n++; @(negedge clk); end
    chk("s1_wr_cycles", n, 3);
    chk("s1_occ0", dut_a.occ_q[0], 1);
    wait_cmd(1'b0, 60, ok);
    chk("s1_second_cmd", ok, 1);
    chk("s1_row1", row_a, 15'h0001);
    wr_en = 1'b0;

    // Two channels alternate; async reset drops outputs mid-command
    do_reset();
    done_dly_a = 2;
    in_lvl = {11'd600, 11'd600}; wr_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_cmd(1'b0, 40, ok);
      chk($sformatf("s2_cmd%0d", k), ok, 1);
      chk($sformatf("s2_ch%0d", k), ch_a, exp_ch[k]);
      chk($sformatf("s2_row%0d", k), row_a, exp_row[k]);
      if (k < 2) begin
        wait_idle(40, ok);
        chk($sformatf("s2_idle%0d", k), ok, 1);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    chk("s2_rst_pagewrite", cw_a, 0);
    chk("s2_rst_busy", busy_a, 0);

    // fill_trigger crosses at 33 rows and clears after one read
    do_reset();
    in_lvl = {11'd0, 11'd600}; wr_en = 1'b1;
    wait_acks(1'b0, 32, 1000, ok);
    chk("s3_acks32", ok, 1);
    repeat (2) @(negedge clk);
    chk("s3_fill_at32", fill_a[0], 0);
    wait_acks(1'b0, 33, 100, ok);
    wr_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("s3_fill_at33", fill_a[0], 1);
    rd_en = 1'b1;
    wait_cmd(1'b0, 20, ok);
    chk("s3_read_cmd", cr_a, 1);
    chk("s3_read_row", row_a, 15'h0000);
    wait_acks(1'b0, 34, 40, ok);
    rd_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("s3_fill_after_read", fill_a[0], 0);

    // Flush during BUSY applied on the first IDLE cycle, beating a read
    do_reset();
    done_dly_a = 4;
    in_lvl = {11'd0, 11'd600}; wr_en = 1'b1;
    wait_acks(1'b0, 5, 200, ok);
    chk("s4_acks5", ok, 1);
    wr_en = 1'b0; rd_en = 1'b1;
    flush = 2'b01;
    @(negedge clk);
    flush = 2'b00;
    chk("s4_occ_before", dut_a.occ_q[0], 5);
    wait_idle(40, ok);
    chk("s4_idle", ok, 1);
    @(negedge clk);
    chk("s4_occ0", dut_a.occ_q[0], 0);
    chk("s4_rptr0", dut_a.rptr_q[0], 5);
    chk("s4_wptr0", dut_a.wptr_q[0], 5);
    chk("s4_no_cmd", busy_a, 0);
    repeat (5) @(negedge clk);
    chk("s4_no_read", cr_a, 0);
    rd_en = 1'b0;

    // Watchdog: no ack ever
    do_reset();
    ack_en_a = 1'b0;
    in_lvl = {11'd0, 11'd600}; wr_en = 1'b1;
    wait_cmd(1'b0, 20, ok);
    wr_en = 1'b0;
    chk("s5_cmd", ok, 1);
    chk("s5_tmo_before", tmo_a, 0);
    n = 0;
    while (cw_a && n < 5000) begin n++; @(negedge clk); end
    chk("s5_wack_cycles", n, 4095);
    chk("s5_timeout", tmo_a, 1);
    chk("s5_idle", busy_a, 0);
    chk("s5_wptr0", dut_a.wptr_q[0], 0);
    chk("s5_occ0", dut_a.occ_q[0], 0);
    ack_en_a = 1'b1;

    // Full ring, stall mode: writes refused, overflow set, reads drain
    do_reset();
    in_lvl = {11'd0, 11'd600}; wr_en = 1'b1;
    wait_acks(1'b0, 4096, 30000, ok);
    chk("s6_acks4096", ok, 1);
    chk("s6_ovf_before", ovf_a[0], 0);
    chk("s6_occ_full", dut_a.occ_q[0], 4096);
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); saw |= cw_a; end
    chk("s6_no_write", saw, 0);
    chk("s6_overflow", ovf_a, 2'b01);
    chk("s6_occ_still", dut_a.occ_q[0], 4096);
    rd_en = 1'b1;
    wait_cmd(1'b0, 20, ok);
    chk("s6_read_cmd", cr_a, 1);
    chk("s6_read_row", row_a, 15'h0000);
    wr_en = 1'b0; rd_en = 1'b0;

    // Full ring, overwrite mode (4-row ring instance)
    do_reset();
    in_lvl = {11'd0, 11'd600}; wr_en = 1'b1;
    wait_acks(1'b1, 4, 200, ok);
    chk("s7_acks4", ok, 1);
    chk("s7_ovf_before", ovf_b[0], 0);
    chk("s7_occ_full", dut_b.occ_q[0], 4);
    wait_cmd(1'b1, 20, ok);
    chk("s7_wr_cmd", cw_b, 1);
    chk("s7_row", row_b, 15'h0000);
    wait_acks(1'b1, 5, 20, ok);
    wr_en = 1'b0;
    chk("s7_acks5", ok, 1);
    chk("s7_rptr0", dut_b.rptr_q[0], 1);
    chk("s7_wptr0", dut_b.wptr_q[0], 1);
    chk("s7_occ_same", dut_b.occ_q[0], 4);
    chk("s7_overflow", ovf_b[0], 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
